// File: rtl/local_oscillator_table_if.sv
// Bus bundle for the double-buffered LO table:
// sample writes, sequencer control and LO outputs.
interface local_oscillator_table_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 18,
   parameter int LANES      = 2
) ();
   localparam int LANE_BITS = $clog2(LANES);
   localparam int ROW_WIDTH = ADDR_WIDTH - LANE_BITS;

   logic                        wEnable;
   logic [ADDR_WIDTH-1:0]       wAddr;
   logic [DATA_WIDTH-1:0]       wData;
   logic [ROW_WIDTH:0]          tableLength;
   logic                        swapRequest;
   logic                        run;
   logic                        sync;
   logic [LANES*DATA_WIDTH-1:0] loData;
   logic                        loValid;
   logic [ROW_WIDTH-1:0]        rowIndex;
   logic                        activeBank;
   logic                        swapPending;

   modport master (
      output wEnable, wAddr, wData, tableLength,
      output swapRequest, run, sync,
      input  loData, loValid, rowIndex,
      input  activeBank, swapPending
   );

   modport slave (
      input  wEnable, wAddr, wData, tableLength,
      input  swapRequest, run, sync,
      output loData, loValid, rowIndex,
      output activeBank, swapPending
   );
endinterface

// File: rtl/local_oscillator_table.sv
// Double-buffered LO table with a phase sequencer.
// Banks swap only at a wrap, a sync or while stopped.
module local_oscillator_table #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 18,
   parameter int LANES      = 2
) (
   input logic                     clk,
   input logic                     resetN,
   local_oscillator_table_if.slave bus
);
   localparam int LANE_BITS = $clog2(LANES);
   localparam int ROW_WIDTH = ADDR_WIDTH - LANE_BITS;
   localparam int DEPTH     = 1 << ROW_WIDTH;
   localparam int LANE_IW   = (LANE_BITS > 0) ? LANE_BITS : 1;
   localparam int ROW_DW    = LANES * DATA_WIDTH;

   logic [DATA_WIDTH-1:0] mem [2][LANES][DEPTH];

   logic [LANE_IW-1:0]   w_lane;
   logic [ROW_WIDTH-1:0] w_row;

   logic [ROW_WIDTH-1:0] row_q;
   logic [ROW_WIDTH-1:0] row_d;
   logic [ROW_WIDTH-1:0] last_q;
   logic [ROW_WIDTH-1:0] last_d;
   logic [ROW_WIDTH-1:0] last_new;
   logic [ROW_WIDTH:0]   len_eff;
   logic                 bank_q;
   logic                 bank_d;
   logic                 pend_q;
   logic                 pend_d;
   logic                 wrap;
   logic                 take;

   logic [ROW_WIDTH-1:0] s1_row;
   logic                 s1_bank;
   logic                 s1_run;

   logic [ROW_DW-1:0]    rd_row;
   logic [ROW_DW-1:0]    lo_data_q;
   logic [ROW_WIDTH-1:0] row_index_q;
   logic                 lo_valid_q;

   generate
      if (LANES == 1) begin : g_one_lane
         assign w_lane = '0;
         assign w_row  = bus.wAddr;
      end else begin : g_multi_lane
         assign w_lane = bus.wAddr[LANE_BITS-1:0];
         assign w_row  = bus.wAddr[ADDR_WIDTH-1:LANE_BITS];
      end
   endgenerate

   // Zero or oversize length selects the full bank depth.
   always_comb begin
      len_eff = bus.tableLength;
      if (bus.tableLength == '0 ||
          bus.tableLength > (ROW_WIDTH+1)'(DEPTH)) begin
         len_eff = (ROW_WIDTH+1)'(DEPTH);
      end
      last_new = ROW_WIDTH'(len_eff - 1'b1);
   end

   always_comb begin
      wrap   = bus.run && (row_q == last_q) && !bus.sync;
      take   = pend_q && (wrap || bus.sync || !bus.run);
      row_d  = row_q;
      last_d = last_q;
      if (bus.sync) begin
         row_d = '0;
      end else if (bus.run) begin
         row_d = (row_q == last_q) ? '0 : row_q + 1'b1;
      end
      if (wrap || bus.sync) begin
         last_d = last_new;
      end
      bank_d = bank_q ^ take;
      pend_d = take ? bus.swapRequest
                    : (pend_q | bus.swapRequest);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         row_q  <= '0;
         last_q <= ROW_WIDTH'(DEPTH - 1);
         bank_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         row_q  <= row_d;
         last_q <= last_d;
         bank_q <= bank_d;
         pend_q <= pend_d;
      end
   end

   // Writes target the bank that is inactive before the edge.
   always_ff @(posedge clk) begin
      if (bus.wEnable) begin
         mem[~bank_q][w_lane][w_row] <= bus.wData;
      end
   end

   always_comb begin
      rd_row = '0;
      for (int k = 0; k < LANES; k++) begin
         rd_row[k*DATA_WIDTH +: DATA_WIDTH] =
            mem[s1_bank][k][s1_row];
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         s1_row      <= '0;
         s1_bank     <= 1'b0;
         s1_run      <= 1'b0;
         lo_data_q   <= '0;
         row_index_q <= '0;
         lo_valid_q  <= 1'b0;
      end else begin
         s1_row     <= row_q;
         s1_bank    <= bank_q;
         s1_run     <= bus.run;
         lo_valid_q <= s1_run;
         if (s1_run) begin
            lo_data_q   <= rd_row;
            row_index_q <= s1_row;
         end
      end
   end

   assign bus.loData      = lo_data_q;
   assign bus.loValid     = lo_valid_q;
   assign bus.rowIndex    = row_index_q;
   assign bus.activeBank  = bank_q;
   assign bus.swapPending = pend_q;
endmodule
